// File: rtl/infer_sched.sv
// rtl/infer_sched.sv - inference job scheduler in front of the CNN core
//
// Purpose: per job, pulse the core reset, stream DATA_LEN image bytes from the
// upstream byte stream, then WGT_LEN weight bytes from the weight RAM, then wait
// for the core result flag (or a timeout) and present the result on a
// valid/ready port.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start                  job request (sampled in IDLE only)
//   busy                   high in every state except IDLE
//   src_valid/src_data     upstream image byte stream
//   src_ready              high only while loading image bytes
//   wgt_addr/wgt_rdata     weight RAM read port (1-cycle read latency)
//   core_rst_n             core reset, active-low
//   core_mode/core_din     byte to core, mode 0 = image, 1 = weight
//   core_ram_en            core write strobe
//   core_dout/core_flag    core result and result-valid flag
//   res_valid/res_ready    result handshake
//   res_data/res_timeout   captured result (0 on timeout), timeout marker
//   job_cnt                accepted results, wraps at 2^16
module infer_sched #(
   parameter int DATA_LEN = 64,
   parameter int WGT_LEN  = 54,
   parameter int RST_CYC  = 2,
   parameter int TIMEOUT  = 255,
   localparam int AW      = $clog2(WGT_LEN)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   input  logic          src_valid,
   input  logic [7:0]    src_data,
   output logic          src_ready,
   output logic [AW-1:0] wgt_addr,
   input  logic [7:0]    wgt_rdata,
   output logic          core_rst_n,
   output logic          core_mode,
   output logic [7:0]    core_din,
   output logic          core_ram_en,
   input  logic [7:0]    core_dout,
   input  logic          core_flag,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [7:0]    res_data,
   output logic          res_timeout,
   output logic [15:0]   job_cnt
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CRST  = 3'd1;
   localparam logic [2:0] S_LDATA = 3'd2;
   localparam logic [2:0] S_LWGT  = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_HOLD  = 3'd5;

   localparam int DW = $clog2(DATA_LEN);
   localparam int WW = $clog2(WGT_LEN + 1);
   localparam int RW = $clog2(RST_CYC + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [DW-1:0] D_LAST = DW'(DATA_LEN - 1);
   localparam logic [WW-1:0] W_LAST = WW'(WGT_LEN);
   localparam logic [RW-1:0] R_LAST = RW'(RST_CYC - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   logic [2:0]    state_q, state_d;
   logic [RW-1:0] r_cnt_q, r_cnt_d;
   logic [DW-1:0] d_cnt_q, d_cnt_d;
   logic [WW-1:0] w_cnt_q, w_cnt_d;
   logic [TW-1:0] t_cnt_q, t_cnt_d;
   logic          core_rst_n_q, core_rst_n_d;
   logic          core_mode_q, core_mode_d;
   logic [7:0]    core_din_q, core_din_d;
   logic          core_ram_en_q, core_ram_en_d;
   logic          res_valid_q, res_valid_d;
   logic [7:0]    res_data_q, res_data_d;
   logic          res_timeout_q, res_timeout_d;
   logic [15:0]   job_cnt_q, job_cnt_d;

   always_comb begin
      state_d       = state_q;
      r_cnt_d       = r_cnt_q;
      d_cnt_d       = d_cnt_q;
      w_cnt_d       = w_cnt_q;
      t_cnt_d       = t_cnt_q;
      core_rst_n_d  = core_rst_n_q;
      core_mode_d   = core_mode_q;
      core_din_d    = core_din_q;
      core_ram_en_d = 1'b0;
      res_valid_d   = res_valid_q;
      res_data_d    = res_data_q;
      res_timeout_d = res_timeout_q;
      job_cnt_d     = job_cnt_q;
      case (state_q)
         S_IDLE: begin
            core_rst_n_d = 1'b1;
            if (start) begin
               state_d      = S_CRST;
               core_rst_n_d = 1'b0;
               r_cnt_d      = '0;
            end
         end
         S_CRST: begin
            core_mode_d = 1'b0;
            if (r_cnt_q == R_LAST) begin
               state_d      = S_LDATA;
               core_rst_n_d = 1'b1;
               d_cnt_d      = '0;
            end else begin
               r_cnt_d = r_cnt_q + 1'b1;
            end
         end
         S_LDATA: begin
            if (src_valid) begin
               core_din_d    = src_data;
               core_mode_d   = 1'b0;
               core_ram_en_d = 1'b1;
               d_cnt_d       = d_cnt_q + 1'b1;
               if (d_cnt_q == D_LAST) begin
                  state_d = S_LWGT;
                  w_cnt_d = '0;
               end
            end
         end
         S_LWGT: begin
            // RAM data lags the address by one cycle: the w_cnt==0 cycle has
            // nothing to forward (bubble), cycle k forwards weight k-1.
            if (w_cnt_q != '0) begin
               core_din_d    = wgt_rdata;
               core_mode_d   = 1'b1;
               core_ram_en_d = 1'b1;
            end
            if (w_cnt_q == W_LAST) begin
               state_d = S_WAIT;
               w_cnt_d = '0;
               t_cnt_d = '0;
            end else begin
               w_cnt_d = w_cnt_q + 1'b1;
            end
         end
         S_WAIT: begin
            t_cnt_d = t_cnt_q + 1'b1;
            // A flag arriving on the final timeout cycle still yields a result.
            if (core_flag) begin
               res_data_d    = core_dout;
               res_timeout_d = 1'b0;
               res_valid_d   = 1'b1;
               state_d       = S_HOLD;
            end else if (t_cnt_q == T_LAST) begin
               res_data_d    = '0;
               res_timeout_d = 1'b1;
               res_valid_d   = 1'b1;
               state_d       = S_HOLD;
            end
         end
         S_HOLD: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               job_cnt_d   = job_cnt_q + 16'd1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         r_cnt_q       <= '0;
         d_cnt_q       <= '0;
         w_cnt_q       <= '0;
         t_cnt_q       <= '0;
         core_rst_n_q  <= 1'b0;
         core_mode_q   <= 1'b0;
         core_din_q    <= '0;
         core_ram_en_q <= 1'b0;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
         res_timeout_q <= 1'b0;
         job_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         r_cnt_q       <= r_cnt_d;
         d_cnt_q       <= d_cnt_d;
         w_cnt_q       <= w_cnt_d;
         t_cnt_q       <= t_cnt_d;
         core_rst_n_q  <= core_rst_n_d;
         core_mode_q   <= core_mode_d;
         core_din_q    <= core_din_d;
         core_ram_en_q <= core_ram_en_d;
         res_valid_q   <= res_valid_d;
         res_data_q    <= res_data_d;
         res_timeout_q <= res_timeout_d;
         job_cnt_q     <= job_cnt_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign src_ready   = (state_q == S_LDATA);
   assign wgt_addr    = w_cnt_q[AW-1:0];
   assign core_rst_n  = core_rst_n_q;
   assign core_mode   = core_mode_q;
   assign core_din    = core_din_q;
   assign core_ram_en = core_ram_en_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign res_timeout = res_timeout_q;
   assign job_cnt     = job_cnt_q;

endmodule

// File: tb/tb_infer_sched.sv
// tb/tb_infer_sched.sv - self-checking bench for infer_sched
module tb_infer_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy;
   logic        src_valid = 1'b0;
   logic [7:0]  src_data = 8'd0;
   logic        src_ready;
   logic [5:0]  wgt_addr;
   logic [7:0]  wgt_rdata = 8'd0;
   logic        core_rst_n;
   logic        core_mode;
   logic [7:0]  core_din;
   logic        core_ram_en;
   logic [7:0]  core_dout = 8'd0;
   logic        core_flag = 1'b0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [7:0]  res_data;
   logic        res_timeout;
   logic [15:0] job_cnt;

   infer_sched dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy),
      .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
      .wgt_addr(wgt_addr), .wgt_rdata(wgt_rdata),
      .core_rst_n(core_rst_n), .core_mode(core_mode), .core_din(core_din),
      .core_ram_en(core_ram_en), .core_dout(core_dout), .core_flag(core_flag),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_timeout(res_timeout), .job_cnt(job_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_jobs = 0;

   logic [7:0] img  [0:63];
   logic [7:0] wmem [0:63];

   // Weight RAM: data for an address shows up one cycle after it is presented.
   logic [5:0] addr_prev = 6'd0;
   always @(negedge clk) begin
      wgt_rdata = wmem[addr_prev];
      addr_prev = wgt_addr;
   end

   // Core model: logs every write, flags 20 cycles after its 118th write.
   int         cyc = 0;
   logic [7:0] d_log [$];
   logic       m_log [$];
   int         c_log [$];
   bit         flag_en = 1'b1;
   logic [7:0] flag_val = 8'h00;
   int         cd = -1;
   int         wr_n = 0;
   int         rstn_low_run = 0;
   int         rstn_low_last = 0;
   always @(negedge clk) begin
      cyc++;
      if (core_ram_en) begin
         d_log.push_back(core_din);
         m_log.push_back(core_mode);
         c_log.push_back(cyc);
      end
      if (!core_rst_n) begin
         wr_n = 0;
         cd = -1;
         core_flag = 1'b0;
         rstn_low_run++;
      end else begin
         if (rstn_low_run > 0) rstn_low_last = rstn_low_run;
         rstn_low_run = 0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               core_flag = 1'b1;
               core_dout = flag_val;
            end
         end
         if (core_ram_en) begin
            wr_n++;
            if (wr_n == 118 && flag_en) cd = 20;
         end
      end
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   // Number of deviations of the logged core writes from the expected job stream.
   function automatic int stream_errors();
      int e = 0;
      if (d_log.size() != 118) return 1000 + d_log.size();
      for (int i = 0; i < 118; i++) begin
         if (i < 64) begin
            if (m_log[i] !== 1'b0 || d_log[i] !== img[i]) e++;
         end else begin
            if (m_log[i] !== 1'b1 || d_log[i] !== wmem[i-64]) e++;
         end
      end
      return e;
   endfunction

   task automatic randomize_job;
      for (int i = 0; i < 64; i++) begin
         img[i]  = 8'($urandom);
         wmem[i] = 8'($urandom);
      end
      flag_val = 8'($urandom);
      flag_en = 1'b1;
   endtask

   int start_cyc;

   task automatic load_job(input int gap);
      int idx = 0;
      int k = 0;
      bit acc;
      d_log.delete(); m_log.delete(); c_log.delete();
      rstn_low_last = 0;
      start = 1'b1;
      start_cyc = cyc;
      tick;
      start = 1'b0;
      while (idx < 64 && k < 500) begin
         case (gap)
            0:       src_valid = 1'b1;
            1:       src_valid = (k % 3 != 2);
            default: src_valid = 1'($urandom_range(0, 1));
         endcase
         src_data = img[idx];
         acc = src_valid && src_ready;
         tick;
         k++;
         if (acc) idx++;
      end
      src_valid = 1'b0;
      n_tests++;
      if (idx !== 64) begin
         n_fail++;
         $display("FAIL load_bytes: accepted %0d, required 64", idx);
      end
   endtask

   task automatic wait_result(output int wait_len);
      int k = 0;
      while (!res_valid && k < 1000) begin
         tick;
         k++;
      end
      n_tests++;
      if (res_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL result_wait: res_valid=%b after %0d cycles, required 1", res_valid, k);
      end
      wait_len = (c_log.size() > 0) ? cyc - c_log[$] : -1;
   endtask

   task automatic accept_result;
      res_ready = 1'b1;
      tick;
      res_ready = 1'b0;
      exp_jobs++;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) tick;
      n_tests++;
      if ({core_rst_n, core_mode, core_din, core_ram_en, wgt_addr, res_valid, res_data,
           res_timeout, job_cnt, busy, src_ready} !== 45'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: rst_n=%b mode=%b din=%h en=%b addr=%h rv=%b rd=%h rt=%b jc=%0d busy=%b rdy=%b, required all 0",
                  core_rst_n, core_mode, core_din, core_ram_en, wgt_addr, res_valid, res_data,
                  res_timeout, job_cnt, busy, src_ready);
      end
      rst = 1'b0;
      exp_jobs = 0;
      repeat (2) tick;
      n_tests++;
      if ({core_rst_n, busy, src_ready, core_ram_en, res_valid, job_cnt} !== {1'b1, 4'b0, 16'd0}) begin
         n_fail++;
         $display("FAIL idle_after_reset: rst_n=%b busy=%b rdy=%b en=%b rv=%b jc=%0d, required rst_n=1 others 0",
                  core_rst_n, busy, src_ready, core_ram_en, res_valid, job_cnt);
      end
   endtask

   task automatic test_basic;
      int wl;
      for (int i = 0; i < 64; i++) begin
         img[i]  = 8'(i);
         wmem[i] = 8'(i + 100);
      end
      flag_val = 8'hF6;
      flag_en = 1'b1;
      load_job(0);
      wait_result(wl);
      n_tests++;
      if (rstn_low_last !== 2) begin
         n_fail++; $display("FAIL basic_core_rst_len: got %0d, required 2", rstn_low_last);
      end
      n_tests++;
      if (c_log.size() < 1 || c_log[0] - start_cyc !== 4) begin
         n_fail++; $display("FAIL basic_latency: got %0d, required 4", c_log.size() ? c_log[0] - start_cyc : -1);
      end
      n_tests++;
      if (stream_errors() !== 0) begin
         n_fail++; $display("FAIL basic_stream: errors %0d, required 0", stream_errors());
      end
      n_tests++;
      if (c_log.size() != 118 || c_log[64] - c_log[63] !== 2 || c_log[117] - c_log[64] !== 53) begin
         n_fail++; $display("FAIL basic_bubble: writes %0d, required one-cycle gap then 54 contiguous", c_log.size());
      end
      n_tests++;
      if ({res_valid, res_data, res_timeout} !== {1'b1, 8'hF6, 1'b0}) begin
         n_fail++; $display("FAIL basic_result: rv=%b rd=%h rt=%b, required 1 f6 0", res_valid, res_data, res_timeout);
      end
      accept_result;
      n_tests++;
      if ({res_valid, busy, job_cnt} !== {1'b0, 1'b0, 16'(exp_jobs)}) begin
         n_fail++; $display("FAIL basic_accept: rv=%b busy=%b jc=%0d, required 0 0 %0d", res_valid, busy, job_cnt, exp_jobs);
      end
   endtask

   task automatic test_gaps;
      int wl;
      randomize_job;
      load_job(1);
      wait_result(wl);
      n_tests++;
      if (stream_errors() !== 0) begin
         n_fail++; $display("FAIL gaps_stream: errors %0d, required 0", stream_errors());
      end
      n_tests++;
      if (c_log.size() < 64 || c_log[63] - c_log[0] <= 63) begin
         n_fail++; $display("FAIL gaps_present: span %0d, required > 63", c_log.size() >= 64 ? c_log[63] - c_log[0] : -1);
      end
      n_tests++;
      if ({res_data, res_timeout} !== {flag_val, 1'b0}) begin
         n_fail++; $display("FAIL gaps_result: rd=%h rt=%b, required %h 0", res_data, res_timeout, flag_val);
      end
      accept_result;
      n_tests++;
      if (job_cnt !== 16'(exp_jobs)) begin
         n_fail++; $display("FAIL gaps_job_cnt: got %0d, required %0d", job_cnt, exp_jobs);
      end
   endtask

   task automatic test_timeout;
      int wl;
      randomize_job;
      flag_en = 1'b0;
      load_job(0);
      wait_result(wl);
      n_tests++;
      if (wl !== 255) begin
         n_fail++; $display("FAIL timeout_wait_len: got %0d, required 255", wl);
      end
      n_tests++;
      if ({res_valid, res_data, res_timeout} !== {1'b1, 8'h00, 1'b1}) begin
         n_fail++; $display("FAIL timeout_result: rv=%b rd=%h rt=%b, required 1 00 1", res_valid, res_data, res_timeout);
      end
      accept_result;
      flag_en = 1'b1;
   endtask

   task automatic test_hold;
      int wl;
      randomize_job;
      load_job(2);
      wait_result(wl);
      for (int i = 0; i < 10; i++) begin
         start = (i == 3 || i == 6);
         tick;
         n_tests++;
         if ({res_valid, res_data, res_timeout, busy, core_rst_n} !== {1'b1, flag_val, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL hold_stable[%0d]: rv=%b rd=%h rt=%b busy=%b rst_n=%b, required 1 %h 0 1 1",
                     i, res_valid, res_data, res_timeout, busy, core_rst_n, flag_val);
         end
      end
      start = 1'b1;
      accept_result;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if ({busy, core_rst_n, res_valid, job_cnt} !== {1'b0, 1'b1, 1'b0, 16'(exp_jobs)}) begin
            n_fail++;
            $display("FAIL hold_after_accept[%0d]: busy=%b rst_n=%b rv=%b jc=%0d, required 0 1 0 %0d",
                     i, busy, core_rst_n, res_valid, job_cnt, exp_jobs);
         end
         tick;
      end
   endtask

   task automatic test_reset_mid;
      int wl;
      int k = 0;
      int seen = 0;
      randomize_job;
      load_job(0);
      while (d_log.size() < 84 && k < 200) begin
         tick;
         k++;
      end
      rst = 1'b1;
      tick;
      n_tests++;
      if ({core_rst_n, res_valid, core_ram_en} !== 3'b000) begin
         n_fail++; $display("FAIL midrst_abort: rst_n=%b rv=%b en=%b, required 000", core_rst_n, res_valid, core_ram_en);
      end
      tick;
      rst = 1'b0;
      exp_jobs = 0;
      for (int i = 0; i < 300; i++) begin
         tick;
         if (res_valid || busy) seen++;
      end
      n_tests++;
      if (seen !== 0 || job_cnt !== 16'(exp_jobs)) begin
         n_fail++; $display("FAIL midrst_no_result: active cycles %0d jc=%0d, required 0 and %0d", seen, job_cnt, exp_jobs);
      end
      randomize_job;
      load_job(0);
      wait_result(wl);
      n_tests++;
      if (rstn_low_last !== 2 || stream_errors() !== 0) begin
         n_fail++; $display("FAIL midrst_new_job: rst_len=%0d errors=%0d, required 2 and 0", rstn_low_last, stream_errors());
      end
      n_tests++;
      if ({res_data, res_timeout} !== {flag_val, 1'b0}) begin
         n_fail++; $display("FAIL midrst_result: rd=%h rt=%b, required %h 0", res_data, res_timeout, flag_val);
      end
      accept_result;
      n_tests++;
      if (job_cnt !== 16'(exp_jobs)) begin
         n_fail++; $display("FAIL midrst_job_cnt: got %0d, required %0d", job_cnt, exp_jobs);
      end
   endtask

   task automatic test_back_to_back;
      int wl;
      for (int j = 0; j < 3; j++) begin
         randomize_job;
         load_job(2);
         wait_result(wl);
         n_tests++;
         if (stream_errors() !== 0 || {res_data, res_timeout} !== {flag_val, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_job[%0d]: errors=%0d rd=%h rt=%b, required 0 %h 0", j, stream_errors(), res_data, res_timeout, flag_val);
         end
         accept_result;
         n_tests++;
         if (job_cnt !== 16'(exp_jobs)) begin
            n_fail++; $display("FAIL b2b_job_cnt[%0d]: got %0d, required %0d", j, job_cnt, exp_jobs);
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_gaps;
      test_timeout;
      test_hold;
      test_reset_mid;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
